// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter sizing rule.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must be able to hold the value WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half-subtractor stages.
// The two stage borrows are ORed to form the borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  assign d1 = a ^ b;
  assign b1 = ~a & b;

  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH, LSB first, one bit per cycle.
// Holds diff and borrow from completion until the next accepted start.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             bin_ff;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;

  full_subtractor u_full_subtractor (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_ff),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      bin_ff  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            bin_ff <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff_sr <= {bit_d, diff_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          bin_ff  <= bit_bout;
          cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_sr;
  assign borrow = bin_ff;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of the bit-serial subtractor at WIDTH=8.
// Edges are counted from the edge that samples start (edge 1 here).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and watches up to 20 edges for done.
  // With hold=1 start stays high and operands change to 1/1 during RUN.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold,
                       output logic [W-1:0] d_o, output logic b_o,
                       output int done_edge, output int busy_cnt, output bit overlap);
    a = av;
    b = bv;
    start = 1'b1;
    done_edge = -1;
    busy_cnt = 0;
    overlap = 1'b0;
    d_o = 'x;
    b_o = 1'bx;
    for (int e = 1; e <= 20 && done_edge < 0; e++) begin
      tick();
      if (hold) begin
        a = 8'd1;
        b = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        done_edge = e;
        d_o = diff;
        b_o = borrow;
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'd200;
    b = 8'd55;
    tick();
    tick();
    checks++;
    if ({busy, done, diff, borrow} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%0d borrow=%b, required 0 0 0 0",
               busy, done, diff, borrow);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] d_o;
    logic b_o;
    int de, bc;
    bit ov;
    do_op(8'd200, 8'd55, 1'b0, d_o, b_o, de, bc, ov);
    checks++;
    if (de !== 9) begin
      errors++;
      $display("FAIL basic_latency: done at edge %0d, required 9", de);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: %0d, required 8", bc);
    end
    checks++;
    if ({d_o, b_o} !== {8'd145, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: diff=%0d borrow=%b, required 145 0", d_o, b_o);
    end
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done_overlap: %b, required 0", ov);
    end
    a = 8'd3;
    b = 8'd9;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({diff, borrow, busy, done} !== {8'd145, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: diff=%0d borrow=%b busy=%b done=%b, required 145 0 0 0",
               diff, borrow, busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{8'd5, 8'd0, 8'd0};
    logic [W-1:0] vb [3] = '{8'd10, 8'd1, 8'd0};
    logic [W-1:0] vd [3] = '{8'd251, 8'd255, 8'd0};
    logic         vbr [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] d_o;
    logic b_o;
    int de, bc;
    bit ov;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, d_o, b_o, de, bc, ov);
      tick();
      checks++;
      if ({d_o, b_o} !== {vd[i], vbr[i]} || de !== 9) begin
        errors++;
        $display("FAIL vector_%0d: diff=%0d borrow=%b edge=%0d, required %0d %b 9",
                 i, d_o, b_o, de, vd[i], vbr[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] d_o;
    logic b_o;
    int de, bc, extra;
    bit ov;
    do_op(8'd200, 8'd55, 1'b1, d_o, b_o, de, bc, ov);
    checks++;
    if ({d_o, b_o} !== {8'd145, 1'b0} || de !== 9) begin
      errors++;
      $display("FAIL start_held_result: diff=%0d borrow=%b edge=%0d, required 145 0 9",
               d_o, b_o, de);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL start_held_single_done: extra done pulses %0d, required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    a = 8'd200;
    b = 8'd55;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, diff, borrow} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b diff=%0d borrow=%b, required 0 0 0 0",
               busy, done, diff, borrow);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: busy/done cycles %0d, required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int first_edge, second_edge;
    logic [W-1:0] d1, d2;
    logic b2;
    first_edge = -1;
    second_edge = -1;
    d1 = 'x;
    d2 = 'x;
    b2 = 1'bx;
    a = 8'd200;
    b = 8'd55;
    start = 1'b1;
    for (int e = 1; e <= 30 && second_edge < 0; e++) begin
      tick();
      start = 1'b0;
      if (first_edge >= 0 && e == first_edge + 1) begin
        a = 8'd255;
        b = 8'd255;
        start = 1'b1;
      end
      if (done) begin
        if (first_edge < 0) begin
          first_edge = e;
          d1 = diff;
        end else begin
          second_edge = e;
          d2 = diff;
          b2 = borrow;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first_edge !== 9 || d1 !== 8'd145) begin
      errors++;
      $display("FAIL b2b_first: edge=%0d diff=%0d, required 9 145", first_edge, d1);
    end
    checks++;
    if (second_edge - first_edge !== 10) begin
      errors++;
      $display("FAIL b2b_gap: %0d cycles, required 10", second_edge - first_edge);
    end
    checks++;
    if ({d2, b2} !== {8'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result: diff=%0d borrow=%b, required 0 0", d2, b2);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, d_o, exp_d;
    logic b_o, exp_b;
    int de, bc;
    bit ov;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom_range(0, 255));
      bv = W'($urandom_range(0, 255));
      exp_d = av - bv;
      exp_b = (av < bv);
      do_op(av, bv, 1'b0, d_o, b_o, de, bc, ov);
      tick();
      checks++;
      if ({d_o, b_o} !== {exp_d, exp_b} || de !== 9 || bc !== 8 || ov) begin
        errors++;
        $display("FAIL random_%0d: a=%0d b=%0d diff=%0d borrow=%b edge=%0d busy=%0d, required %0d %b 9 8",
                 i, av, bv, d_o, b_o, de, bc, exp_d, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
